// File: rtl/bru_pkg.sv
// Shared opcode constants, branch condition encodings and the resolved-result
// record used by the branch resolve unit and its condition evaluator.
package bru_pkg;

  localparam int BRU_XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef struct packed {
    logic                ctrl;
    logic                taken;
    logic                illegal;
    logic [BRU_XLEN-1:0] target;
    logic [BRU_XLEN-1:0] link;
  } bru_result_t;

endpackage

// File: rtl/bru_cond.sv
// Combinational branch condition evaluator: decides taken for the six
// conditional branches and flags the two reserved funct3 encodings.
module bru_cond
  import bru_pkg::*;
#(
  parameter int XLEN = BRU_XLEN
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  logic eq_s;
  logic lt_s;
  logic ltu_s;

  assign eq_s  = (rs1 == rs2);
  assign lt_s  = ($signed(rs1) < $signed(rs2));
  assign ltu_s = (rs1 < rs2);

  // Select the comparison named by funct3; reserved encodings never take.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3_e'(funct3))
      F3_BEQ:  taken = eq_s;
      F3_BNE:  taken = !eq_s;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = ltu_s;
      F3_BGEU: taken = !ltu_s;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined resolution of BRANCH/JAL/JALR with mispredict detection behind a
// valid/ready handshake. Optional target alignment check: BRU_MISALIGN_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN       = BRU_XLEN,
  parameter int PIPE_DEPTH = 1,
  parameter int IALIGN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_ctrl,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic [XLEN-1:0] out_redirect_pc,
`ifdef BRU_MISALIGN_EN
  output logic            out_misaligned,
`endif
  output logic            out_illegal
);

  if (!((PIPE_DEPTH == 1) || (PIPE_DEPTH == 2)) || !((IALIGN == 16) || (IALIGN == 32))) begin : g_bad_cfg
    $error("branch_resolve_unit: PIPE_DEPTH must be 1 or 2 and IALIGN 16 or 32");
  end

  logic            cond_taken_s;
  logic            cond_illegal_s;
  logic [XLEN-1:0] jalr_sum_s;
  bru_result_t     res_s;

  bru_cond #(.XLEN(XLEN)) u_cond (
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .taken   (cond_taken_s),
    .illegal (cond_illegal_s)
  );

  assign jalr_sum_s = rs1 + imm;

  // Decode and resolve the incoming op into a result record.
  always_comb begin
    res_s.ctrl    = 1'b0;
    res_s.taken   = 1'b0;
    res_s.illegal = 1'b0;
    res_s.target  = pc + imm;
    res_s.link    = pc + XLEN'(3'd4);
    case (opcode)
      OP_BRANCH: begin
        res_s.ctrl    = 1'b1;
        res_s.taken   = cond_taken_s;
        res_s.illegal = cond_illegal_s;
      end
      OP_JAL: begin
        res_s.ctrl  = 1'b1;
        res_s.taken = 1'b1;
      end
      OP_JALR: begin
        res_s.ctrl   = 1'b1;
        res_s.taken  = 1'b1;
        res_s.target = jalr_sum_s & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      default: begin
        res_s.ctrl = 1'b0;
      end
    endcase
  end

  // Signals feeding the output register, sourced from either the inputs
  // (depth 1) or the stage-1 register (depth 2).
  logic            out_stage_ready_s;
  logic            late_valid_s;
  bru_result_t     late_res_s;
  logic            late_pt_s;
  logic [XLEN-1:0] late_ptgt_s;

  assign out_stage_ready_s = !out_valid || out_ready;

  if (PIPE_DEPTH == 2) begin : g_two
    logic            s1_valid_r;
    bru_result_t     s1_res_r;
    logic            s1_pt_r;
    logic [XLEN-1:0] s1_ptgt_r;

    assign in_ready = !s1_valid_r || out_stage_ready_s;

    // Stage 1 captures the resolved op together with the prediction it is checked against.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_r <= 1'b0;
        s1_res_r   <= '{ctrl: 1'b0, taken: 1'b0, illegal: 1'b0,
                        target: {BRU_XLEN{1'b0}}, link: {BRU_XLEN{1'b0}}};
        s1_pt_r    <= 1'b0;
        s1_ptgt_r  <= {XLEN{1'b0}};
      end else if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (in_ready) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_res_r  <= res_s;
          s1_pt_r   <= pred_taken;
          s1_ptgt_r <= pred_target;
        end
      end
    end

    assign late_valid_s = s1_valid_r;
    assign late_res_s   = s1_res_r;
    assign late_pt_s    = s1_pt_r;
    assign late_ptgt_s  = s1_ptgt_r;
  end else begin : g_one
    assign in_ready     = out_stage_ready_s;
    assign late_valid_s = in_valid;
    assign late_res_s   = res_s;
    assign late_pt_s    = pred_taken;
    assign late_ptgt_s  = pred_target;
  end

  logic            late_misp_s;
  logic [XLEN-1:0] late_redirect_s;

`ifdef BRU_MISALIGN_EN
  function automatic logic target_misaligned(input logic [XLEN-1:0] t);
    if (IALIGN == 16) begin
      return t[0];
    end else begin
      return |t[1:0];
    end
  endfunction

  logic late_misal_s;
`endif

  // Compare the resolution against the prediction and pick the correct next PC.
  always_comb begin
    late_redirect_s = late_res_s.taken ? late_res_s.target : late_res_s.link;
`ifdef BRU_MISALIGN_EN
    late_misal_s = late_res_s.ctrl && late_res_s.taken && target_misaligned(late_res_s.target);
    // A misaligned target traps; the trap path owns the redirect.
    late_misp_s  = late_res_s.ctrl && !late_misal_s &&
                   ((late_res_s.taken != late_pt_s) ||
                    (late_res_s.taken && (late_res_s.target != late_ptgt_s)));
`else
    late_misp_s  = late_res_s.ctrl &&
                   ((late_res_s.taken != late_pt_s) ||
                    (late_res_s.taken && (late_res_s.target != late_ptgt_s)));
`endif
  end

  // Output stage holds the result until the consumer accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_ctrl        <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= {XLEN{1'b0}};
      out_link        <= {XLEN{1'b0}};
      out_mispredict  <= 1'b0;
      out_redirect_pc <= {XLEN{1'b0}};
      out_illegal     <= 1'b0;
`ifdef BRU_MISALIGN_EN
      out_misaligned  <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_stage_ready_s) begin
      out_valid <= late_valid_s;
      if (late_valid_s) begin
        out_ctrl        <= late_res_s.ctrl;
        out_taken       <= late_res_s.taken;
        out_target      <= late_res_s.target;
        out_link        <= late_res_s.link;
        out_mispredict  <= late_misp_s;
        out_redirect_pc <= late_redirect_s;
        out_illegal     <= late_res_s.illegal;
`ifdef BRU_MISALIGN_EN
        out_misaligned  <= late_misal_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed vector table on a depth-1 unit, handshake,
// flush and reset sequences on a depth-2 unit, random traffic on both.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        pt;
    logic [31:0] ptgt;
  } vec_t;

  typedef struct packed {
    logic        ctrl, taken;
    logic [31:0] target, link;
    logic        misp;
    logic [31:0] redir;
    logic        illegal, misal;
  } res_t;

  typedef struct {
    string nm;
    vec_t  v;
    res_t  e;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [31:0] pc, rs1, rs2, imm, pred_target;
  logic pred_taken;

  logic in_valid1, out_ready1, flush1, in_ready1, out_valid1;
  logic out_ctrl1, out_taken1, out_mispredict1, out_illegal1, out_misaligned1;
  logic [31:0] out_target1, out_link1, out_redirect_pc1;
  logic in_valid2, out_ready2, flush2, in_ready2, out_valid2;
  logic out_ctrl2, out_taken2, out_mispredict2, out_illegal2, out_misaligned2;
  logic [31:0] out_target2, out_link2, out_redirect_pc2;

  int checks = 0;
  int errors = 0;
  int delivered2 = 0;
  bit stall_seen = 1'b0;
  res_t q1[$];
  res_t q2[$];
  res_t got1, got2;
  tv_t tbl[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .PIPE_DEPTH(1), .IALIGN(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .opcode(opcode), .funct3(funct3), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_taken(out_taken1),
    .out_target(out_target1), .out_link(out_link1), .out_mispredict(out_mispredict1),
    .out_redirect_pc(out_redirect_pc1),
`ifdef BRU_MISALIGN_EN
    .out_misaligned(out_misaligned1),
`endif
    .out_illegal(out_illegal1)
  );

  branch_resolve_unit #(.XLEN(32), .PIPE_DEPTH(2), .IALIGN(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .opcode(opcode), .funct3(funct3), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_taken(out_taken2),
    .out_target(out_target2), .out_link(out_link2), .out_mispredict(out_mispredict2),
    .out_redirect_pc(out_redirect_pc2),
`ifdef BRU_MISALIGN_EN
    .out_misaligned(out_misaligned2),
`endif
    .out_illegal(out_illegal2)
  );

`ifndef BRU_MISALIGN_EN
  assign out_misaligned1 = 1'b0;
  assign out_misaligned2 = 1'b0;
`endif

  always_comb begin
    got1 = {out_ctrl1, out_taken1, out_target1, out_link1, out_mispredict1,
            out_redirect_pc1, out_illegal1, out_misaligned1};
    got2 = {out_ctrl2, out_taken2, out_target2, out_link2, out_mispredict2,
            out_redirect_pc2, out_illegal2, out_misaligned2};
  end

  function automatic vec_t mk_vec(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] pc_v, rs1_v, rs2_v, imm_v,
                                  input logic pt_v, input logic [31:0] ptgt_v);
    return {op, f3, pc_v, rs1_v, rs2_v, imm_v, pt_v, ptgt_v};
  endfunction

  function automatic res_t mk_res(input logic c, t, input logic [31:0] tgt, lnk,
                                  input logic m, input logic [31:0] rd, input logic il, ma);
    return {c, t, tgt, lnk, m, rd, il, ma};
  endfunction

  // Reference model: the architectural rules stated directly with plain arithmetic.
  function automatic res_t model(input vec_t v);
    res_t r;
    r = '0;
    r.link = v.pc + 32'd4;
    r.target = v.pc + v.imm;
    if (v.opcode == OP_BRANCH) begin
      r.ctrl = 1'b1;
      case (v.funct3)
        3'd0: r.taken = (v.rs1 == v.rs2);
        3'd1: r.taken = (v.rs1 != v.rs2);
        3'd4: r.taken = ($signed(v.rs1) < $signed(v.rs2));
        3'd5: r.taken = ($signed(v.rs1) >= $signed(v.rs2));
        3'd6: r.taken = (v.rs1 < v.rs2);
        3'd7: r.taken = (v.rs1 >= v.rs2);
        default: r.illegal = 1'b1;
      endcase
    end else if (v.opcode == OP_JAL) begin
      r.ctrl = 1'b1;
      r.taken = 1'b1;
    end else if (v.opcode == OP_JALR) begin
      r.ctrl = 1'b1;
      r.taken = 1'b1;
      r.target = v.rs1 + v.imm;
      if (r.target % 2 != 0) r.target = r.target - 32'd1;
    end
    r.misp = r.ctrl && ((r.taken != v.pt) || (r.taken && r.target != v.ptgt));
`ifdef BRU_MISALIGN_EN
    r.misal = r.ctrl && r.taken && (r.target % 4 != 0);
    if (r.misal) r.misp = 1'b0;
`endif
    r.redir = r.taken ? r.target : r.link;
    return r;
  endfunction

  function automatic vec_t cur_vec();
    return {opcode, funct3, pc, rs1, rs2, imm, pred_taken, pred_target};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    res_t r;
    int k;
    k = $urandom_range(0, 9);
    v.opcode = (k < 5) ? OP_BRANCH : (k < 7) ? OP_JAL : (k < 9) ? OP_JALR : 7'h13;
    v.funct3 = 3'($urandom_range(0, 7));
    v.pc = $urandom;
    if ($urandom_range(0, 3) != 0) v.pc[1:0] = 2'b00;
    v.rs1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7)) - 32'd3;
    v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
    v.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
    v.pt = 1'($urandom_range(0, 1));
    v.ptgt = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      r = model(v);
      v.ptgt = r.target;
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {opcode, funct3, pc, rs1, rs2, imm, pred_taken, pred_target} = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Target is only meaningful for control ops unless strict is set.
  task automatic cmp(input string nm, input res_t got, input res_t exp, input bit strict);
    res_t g;
    g = got;
    if (!strict && !exp.ctrl) g.target = exp.target;
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s: got ctrl=%b taken=%b tgt=%h link=%h misp=%b redir=%h ill=%b mal=%b expected ctrl=%b taken=%b tgt=%h link=%h misp=%b redir=%h ill=%b mal=%b",
               nm, got.ctrl, got.taken, got.target, got.link, got.misp, got.redir, got.illegal, got.misal,
               exp.ctrl, exp.taken, exp.target, exp.link, exp.misp, exp.redir, exp.illegal, exp.misal);
    end
  endtask

  // Scoreboard for the depth-1 unit.
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
    end else begin
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d1_extra: got an output with no expected entry");
        end else begin
          cmp("d1_stream", got1, q1.pop_front(), 1'b0);
        end
      end
      if (flush1) q1.delete();
      else if (in_valid1 && in_ready1) q1.push_back(model(cur_vec()));
    end
  end

  // Scoreboard for the depth-2 unit.
  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete();
    end else begin
      if (!in_ready2) stall_seen = 1'b1;
      if (out_valid2 && out_ready2) begin
        delivered2++;
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d2_extra: got an output with no expected entry");
        end else begin
          cmp("d2_stream", got2, q2.pop_front(), 1'b0);
        end
      end
      if (flush2) q2.delete();
      else if (in_valid2 && in_ready2) q2.push_back(model(cur_vec()));
    end
  end

  task automatic issue2(input vec_t v, output int waited);
    drive(v);
    in_valid2 = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("issue2_timeout", 32'(in_ready2), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      drive(rand_vec());
      if (sel == 1) begin
        in_valid1 = ($urandom_range(0, 9) < 7);
        out_ready1 = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid2 = ($urandom_range(0, 9) < 7);
        out_ready2 = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk);
      #1;
    end
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    out_ready1 = 1'b1;
    out_ready2 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk((sel == 1) ? "d1_drain" : "d2_drain", 32'((sel == 1) ? q1.size() : q2.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    int wsum;
    int base;
    vec_t va, vb, vc;
    res_t e_misal;

    rst_n = 1'b0;
    drive(mk_vec(7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0));
    in_valid1 = 1'b0; out_ready1 = 1'b1; flush1 = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; flush2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov1", 32'(out_valid1), 32'd0);
    chk("rst_ov2", 32'(out_valid2), 32'd0);
    cmp("rst_data1", got1, '0, 1'b1);
    cmp("rst_data2", got2, '0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy1_after_rst", 32'(in_ready1), 32'd1);
    chk("rdy2_after_rst", 32'(in_ready2), 32'd1);

    tbl.push_back('{"beq_taken", mk_vec(OP_BRANCH, 3'd0, 32'h100, 32'h5, 32'h5, 32'h20, 1'b0, 32'h0),
                   mk_res(1'b1, 1'b1, 32'h120, 32'h104, 1'b1, 32'h120, 1'b0, 1'b0)});
    tbl.push_back('{"blt_signed", mk_vec(OP_BRANCH, 3'd4, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b1, 32'h120),
                   mk_res(1'b1, 1'b1, 32'h120, 32'h104, 1'b0, 32'h120, 1'b0, 1'b0)});
    tbl.push_back('{"bltu", mk_vec(OP_BRANCH, 3'd6, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b1, 32'h120),
                   mk_res(1'b1, 1'b0, 32'h120, 32'h104, 1'b1, 32'h104, 1'b0, 1'b0)});
    tbl.push_back('{"bgeu", mk_vec(OP_BRANCH, 3'd7, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0),
                   mk_res(1'b1, 1'b1, 32'h120, 32'h104, 1'b1, 32'h120, 1'b0, 1'b0)});
    tbl.push_back('{"bge_signed", mk_vec(OP_BRANCH, 3'd5, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0),
                   mk_res(1'b1, 1'b0, 32'h120, 32'h104, 1'b0, 32'h104, 1'b0, 1'b0)});
    tbl.push_back('{"bne_bad_tgt", mk_vec(OP_BRANCH, 3'd1, 32'h100, 32'h3, 32'h4, 32'hFFFFFFF0, 1'b1, 32'h90),
                   mk_res(1'b1, 1'b1, 32'hF0, 32'h104, 1'b1, 32'hF0, 1'b0, 1'b0)});
    tbl.push_back('{"jalr", mk_vec(OP_JALR, 3'd0, 32'h200, 32'h1001, 32'h0, 32'h4, 1'b1, 32'h1004),
                   mk_res(1'b1, 1'b1, 32'h1004, 32'h204, 1'b0, 32'h1004, 1'b0, 1'b0)});
    tbl.push_back('{"illegal_010", mk_vec(OP_BRANCH, 3'd2, 32'h100, 32'h5, 32'h5, 32'h20, 1'b0, 32'h0),
                   mk_res(1'b1, 1'b0, 32'h120, 32'h104, 1'b0, 32'h104, 1'b1, 1'b0)});
    tbl.push_back('{"illegal_011", mk_vec(OP_BRANCH, 3'd3, 32'h100, 32'h5, 32'h5, 32'h20, 1'b1, 32'h120),
                   mk_res(1'b1, 1'b0, 32'h120, 32'h104, 1'b1, 32'h104, 1'b1, 1'b0)});
    tbl.push_back('{"jal_wrap", mk_vec(OP_JAL, 3'd0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h8, 1'b1, 32'h4),
                   mk_res(1'b1, 1'b1, 32'h4, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0)});
    tbl.push_back('{"non_ctrl", mk_vec(7'h33, 3'd0, 32'h300, 32'h1, 32'h1, 32'h4, 1'b1, 32'h304),
                   mk_res(1'b0, 1'b0, 32'h0, 32'h304, 1'b0, 32'h304, 1'b0, 1'b0)});
`ifdef BRU_MISALIGN_EN
    e_misal = mk_res(1'b1, 1'b1, 32'h102, 32'h104, 1'b0, 32'h102, 1'b0, 1'b1);
`else
    e_misal = mk_res(1'b1, 1'b1, 32'h102, 32'h104, 1'b1, 32'h102, 1'b0, 1'b0);
`endif
    tbl.push_back('{"jal_misaligned", mk_vec(OP_JAL, 3'd0, 32'h100, 32'h0, 32'h0, 32'h2, 1'b0, 32'h0), e_misal});

    // Back-to-back table on the depth-1 unit: each result one cycle after accept.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v);
      in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      chk({tbl[i].nm, "_valid"}, 32'(out_valid1), 32'd1);
      cmp(tbl[i].nm, got1, tbl[i].e, 1'b0);
    end
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    chk("d1_idle", 32'(out_valid1), 32'd0);

    run_random(1, 300);

    // Depth 2: four ops with a three-cycle consumer stall in the middle.
    base = delivered2;
    stall_seen = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) issue2(rand_vec(), w);
        in_valid2 = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready2 = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("stall_in_ready_drop", 32'(stall_seen), 32'd1);
    chk("stall_delivered", 32'(delivered2 - base), 32'd4);
    chk("stall_queue_empty", 32'(q2.size()), 32'd0);

    base = delivered2;
    wsum = 0;
    for (int k = 0; k < 6; k++) begin
      issue2(rand_vec(), w);
      wsum += w;
    end
    in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("tput_waits", 32'(wsum), 32'd0);
    chk("tput_delivered", 32'(delivered2 - base), 32'd6);

    // Flush with one op in flight and another handshaking in the same cycle.
    va = mk_vec(OP_JAL, 3'd0, 32'h400, 32'h0, 32'h0, 32'h40, 1'b0, 32'h0);
    vb = mk_vec(OP_BRANCH, 3'd0, 32'h500, 32'h7, 32'h7, 32'h10, 1'b0, 32'h0);
    vc = mk_vec(OP_BRANCH, 3'd1, 32'h600, 32'h7, 32'h8, 32'h30, 1'b1, 32'h630);
    drive(va);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    drive(vb);
    flush2 = 1'b1;
    @(posedge clk);
    #1;
    flush2 = 1'b0;
    in_valid2 = 1'b0;
    chk("flush_ov_a", 32'(out_valid2), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_ov_b", 32'(out_valid2), 32'd0);
    drive(vc);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    chk("post_flush_lat1", 32'(out_valid2), 32'd0);
    @(posedge clk);
    #1;
    chk("post_flush_lat2", 32'(out_valid2), 32'd1);
    cmp("post_flush_data", got2, mk_res(1'b1, 1'b1, 32'h630, 32'h604, 1'b0, 32'h630, 1'b0, 1'b0), 1'b0);

    run_random(2, 300);

    // Reset while an op sits in stage 1: it must never appear.
    drive(va);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_out", 32'(out_valid2), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
